// File: rtl/oled_power_sequencer_pkg.sv
// Shared state encoding, command ROM and segment bounds for the SSD1306 power sequencer.
// Defining OLED_SEQ_POWERDOWN_EN adds the power-down states and the trailing display-off byte.
package oled_seq_pkg;

  typedef enum logic [3:0] {
    ST_OFF       = 4'd0,
    ST_VDD_WAIT  = 4'd1,
    ST_SEND0     = 4'd2,
    ST_RES_LOW   = 4'd3,
    ST_RES_HIGH  = 4'd4,
    ST_SEND_PUMP = 4'd5,
    ST_VBAT_WAIT = 4'd6,
    ST_SEND_CFG  = 4'd7,
    ST_READY     = 4'd8
`ifdef OLED_SEQ_POWERDOWN_EN
    ,
    ST_PD_SEND   = 4'd9,
    ST_PD_VBAT   = 4'd10
`endif
  } seq_state_t;

  localparam int unsigned IDX_W = 4;
  typedef logic [IDX_W-1:0] cmd_idx_t;

`ifdef OLED_SEQ_POWERDOWN_EN
  localparam int unsigned CMD_ROM_LEN = 13;
  localparam logic [7:0] CMD_ROM [0:CMD_ROM_LEN-1] = '{
    8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F,
    8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF, 8'hAE
  };
`else
  localparam int unsigned CMD_ROM_LEN = 12;
  localparam logic [7:0] CMD_ROM [0:CMD_ROM_LEN-1] = '{
    8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F,
    8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF
  };
`endif

  localparam cmd_idx_t SEG0_FIRST = 4'd0;
  localparam cmd_idx_t SEG0_LAST  = 4'd0;
  localparam cmd_idx_t PUMP_FIRST = 4'd1;
  localparam cmd_idx_t PUMP_LAST  = 4'd4;
  localparam cmd_idx_t CFG_FIRST  = 4'd5;
  localparam cmd_idx_t CFG_LAST   = 4'd11;
`ifdef OLED_SEQ_POWERDOWN_EN
  localparam cmd_idx_t PD_FIRST   = 4'd12;
  localparam cmd_idx_t PD_LAST    = 4'd12;
`endif

endpackage

// File: rtl/oled_power_sequencer_if.sv
// Command-byte handshake between the power sequencer and the SPI byte transmitter.
interface oled_power_sequencer_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       spi_idle;
  logic       dc;

  modport master (output cmd_valid, cmd_data, dc, input cmd_ready, spi_idle);
  modport slave  (input cmd_valid, cmd_data, dc, output cmd_ready, spi_idle);
endinterface

// File: rtl/oled_power_sequencer_timer.sv
// Loadable down-counter shared by every rail and reset delay; done while the count is zero.
module oled_seq_timer #(
  parameter int unsigned TW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] n,
  output logic          done
);
  logic [TW-1:0] cnt_r;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= n;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - TW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == '0);
endmodule

// File: rtl/oled_power_sequencer.sv
// SSD1306 power-up (and optional power-down) sequencer driving rails, RES# and command bytes.
// Power-down support is enabled by defining OLED_SEQ_POWERDOWN_EN.
module oled_power_sequencer
  import oled_seq_pkg::*;
#(
  parameter int unsigned T_VDD  = 100_000,
  parameter int unsigned T_RES  = 100_000,
  parameter int unsigned T_VBAT = 10_000_000,
  parameter int unsigned TW     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  output logic                          ready,
  output logic                          busy,
  output logic                          vdd_en_n,
  output logic                          vbat_en_n,
  output logic                          res_n,
  oled_power_sequencer_if.master        cmd
);
  seq_state_t    state_r;
  cmd_idx_t      idx_r;
  cmd_idx_t      seg_last_s;
  logic          cmd_valid_r;
  logic [7:0]    cmd_data_r;
  logic          in_send_s;
  logic          seg_exit_s;
  logic          tmr_load_s;
  logic          tmr_done_s;
  logic [TW-1:0] tmr_n_s;

  assign cmd.cmd_valid = cmd_valid_r;
  assign cmd.cmd_data  = cmd_data_r;
  assign cmd.dc        = 1'b0;

  // Identify the active send segment and its final ROM index.
  always_comb begin
    in_send_s  = 1'b1;
    seg_last_s = SEG0_LAST;
    case (state_r)
      ST_SEND0:     seg_last_s = SEG0_LAST;
      ST_SEND_PUMP: seg_last_s = PUMP_LAST;
      ST_SEND_CFG:  seg_last_s = CFG_LAST;
`ifdef OLED_SEQ_POWERDOWN_EN
      ST_PD_SEND:   seg_last_s = PD_LAST;
`endif
      default: begin
        in_send_s  = 1'b0;
        seg_last_s = SEG0_LAST;
      end
    endcase
  end

  // A segment is finished once its last byte is gone and the transmitter has drained.
  assign seg_exit_s = in_send_s && !cmd_valid_r && cmd.spi_idle;

  // Reload the timer with T-1 on the very edge that enters a wait state.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_n_s    = '0;
    case (state_r)
      ST_OFF: begin
        tmr_load_s = start;
        tmr_n_s    = TW'(T_VDD - 32'd1);
      end
      ST_SEND0: begin
        tmr_load_s = seg_exit_s;
        tmr_n_s    = TW'(T_RES - 32'd1);
      end
      ST_RES_LOW: begin
        tmr_load_s = tmr_done_s;
        tmr_n_s    = TW'(T_RES - 32'd1);
      end
      ST_SEND_PUMP: begin
        tmr_load_s = seg_exit_s;
        tmr_n_s    = TW'(T_VBAT - 32'd1);
      end
`ifdef OLED_SEQ_POWERDOWN_EN
      ST_PD_SEND: begin
        tmr_load_s = seg_exit_s;
        tmr_n_s    = TW'(T_VBAT - 32'd1);
      end
`endif
      default: begin
        tmr_load_s = 1'b0;
        tmr_n_s    = '0;
      end
    endcase
  end

  oled_seq_timer #(.TW(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load_s),
    .n    (tmr_n_s),
    .done (tmr_done_s)
  );

`ifdef OLED_SEQ_POWERDOWN_EN
  logic stop_pend_r;
  logic in_powerup_s;
  assign in_powerup_s = (state_r != ST_OFF) && (state_r != ST_READY) &&
                        (state_r != ST_PD_SEND) && (state_r != ST_PD_VBAT);
`else
  logic unused_stop_s;
  assign unused_stop_s = stop;
`endif

  // Sequencer FSM; every pin and handshake output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_OFF;
      idx_r       <= '0;
      cmd_valid_r <= 1'b0;
      cmd_data_r  <= 8'h00;
      ready       <= 1'b0;
      busy        <= 1'b0;
      vdd_en_n    <= 1'b1;
      vbat_en_n   <= 1'b1;
      res_n       <= 1'b1;
`ifdef OLED_SEQ_POWERDOWN_EN
      stop_pend_r <= 1'b0;
`endif
    end else begin
      // Byte stepping: valid stays up and data stays put until the transmitter takes it.
      if (in_send_s && cmd_valid_r && cmd.cmd_ready) begin
        if (idx_r == seg_last_s) begin
          cmd_valid_r <= 1'b0;
        end else begin
          idx_r      <= idx_r + 4'd1;
          cmd_data_r <= CMD_ROM[idx_r + 4'd1];
        end
      end
`ifdef OLED_SEQ_POWERDOWN_EN
      if (stop && in_powerup_s) begin
        stop_pend_r <= 1'b1;
      end
`endif
      case (state_r)
        ST_OFF: begin
          if (start) begin
            state_r  <= ST_VDD_WAIT;
            vdd_en_n <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_VDD_WAIT: begin
          if (tmr_done_s) begin
            state_r     <= ST_SEND0;
            idx_r       <= SEG0_FIRST;
            cmd_data_r  <= CMD_ROM[SEG0_FIRST];
            cmd_valid_r <= 1'b1;
          end
        end
        ST_SEND0: begin
          if (seg_exit_s) begin
            state_r <= ST_RES_LOW;
            res_n   <= 1'b0;
          end
        end
        ST_RES_LOW: begin
          if (tmr_done_s) begin
            state_r <= ST_RES_HIGH;
            res_n   <= 1'b1;
          end
        end
        ST_RES_HIGH: begin
          if (tmr_done_s) begin
            state_r     <= ST_SEND_PUMP;
            idx_r       <= PUMP_FIRST;
            cmd_data_r  <= CMD_ROM[PUMP_FIRST];
            cmd_valid_r <= 1'b1;
          end
        end
        ST_SEND_PUMP: begin
          if (seg_exit_s) begin
            state_r   <= ST_VBAT_WAIT;
            vbat_en_n <= 1'b0;
          end
        end
        ST_VBAT_WAIT: begin
          if (tmr_done_s) begin
            state_r     <= ST_SEND_CFG;
            idx_r       <= CFG_FIRST;
            cmd_data_r  <= CMD_ROM[CFG_FIRST];
            cmd_valid_r <= 1'b1;
          end
        end
        ST_SEND_CFG: begin
          if (seg_exit_s) begin
`ifdef OLED_SEQ_POWERDOWN_EN
            // A stop seen during power-up skips READY and heads straight into power-down.
            if (stop_pend_r || stop) begin
              state_r     <= ST_PD_SEND;
              stop_pend_r <= 1'b0;
              idx_r       <= PD_FIRST;
              cmd_data_r  <= CMD_ROM[PD_FIRST];
              cmd_valid_r <= 1'b1;
            end else begin
              state_r <= ST_READY;
              ready   <= 1'b1;
              busy    <= 1'b0;
            end
`else
            state_r <= ST_READY;
            ready   <= 1'b1;
            busy    <= 1'b0;
`endif
          end
        end
`ifdef OLED_SEQ_POWERDOWN_EN
        ST_READY: begin
          if (stop) begin
            state_r     <= ST_PD_SEND;
            ready       <= 1'b0;
            busy        <= 1'b1;
            idx_r       <= PD_FIRST;
            cmd_data_r  <= CMD_ROM[PD_FIRST];
            cmd_valid_r <= 1'b1;
          end
        end
        ST_PD_SEND: begin
          if (seg_exit_s) begin
            state_r   <= ST_PD_VBAT;
            vbat_en_n <= 1'b1;
          end
        end
        ST_PD_VBAT: begin
          if (tmr_done_s) begin
            state_r  <= ST_OFF;
            vdd_en_n <= 1'b1;
            busy     <= 1'b0;
          end
        end
`else
        ST_READY: state_r <= ST_READY;
`endif
        default: begin
          state_r     <= ST_OFF;
          cmd_valid_r <= 1'b0;
          ready       <= 1'b0;
          busy        <= 1'b0;
          vdd_en_n    <= 1'b1;
          vbat_en_n   <= 1'b1;
          res_n       <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_oled_power_sequencer.sv
// Directed bench for oled_power_sequencer: byte scoreboard, rail/reset timing and handshake stability.
module tb_oled_power_sequencer;
  localparam int unsigned T_VDD  = 10;
  localparam int unsigned T_RES  = 3;
  localparam int unsigned T_VBAT = 20;

  logic clk = 1'b0;
  logic rst, start, stop, ready, busy, vdd_en_n, vbat_en_n, res_n;

  oled_power_sequencer_if cmd_if();

  oled_power_sequencer #(.T_VDD(T_VDD), .T_RES(T_RES), .T_VBAT(T_VBAT), .TW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .ready     (ready),
    .busy      (busy),
    .vdd_en_n  (vdd_en_n),
    .vbat_en_n (vbat_en_n),
    .res_n     (res_n),
    .cmd       (cmd_if)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_seq [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
  logic [7:0] sb_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int idle_hold = 0;
  bit arm_idle = 1'b0;
  int t_vdd_on, t_valid_on, t_vbat_on, t_ready_on, t_vbat_off, t_vdd_off, res_low_cnt;
  bit ready_seen;
  logic prev_vdd, prev_vbat, prev_valid, prev_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    t_vdd_on = -1; t_valid_on = -1; t_vbat_on = -1; t_ready_on = -1;
    t_vbat_off = -1; t_vdd_off = -1; res_low_cnt = 0; ready_seen = 1'b0;
  endtask

  // One clock: drive handshake inputs, score accepted bytes, then observe outputs #1 after the edge.
  task automatic tick();
    logic       accept, stall;
    logic [7:0] held, exp_b;
    cmd_if.cmd_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 2);
    cmd_if.spi_idle  = (idle_hold > 0) ? 1'b0 : 1'b1;
    accept = cmd_if.cmd_valid && cmd_if.cmd_ready;
    stall  = cmd_if.cmd_valid && !cmd_if.cmd_ready;
    held   = cmd_if.cmd_data;
    if (accept) begin
      exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      chk("cmd_byte", {24'd0, held}, {24'd0, exp_b});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (idle_hold > 0) idle_hold--;
    if (accept && arm_idle && held == 8'hF1) idle_hold = 5;
    if (stall) begin
      chk("hold_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
      chk("hold_data", {24'd0, cmd_if.cmd_data}, {24'd0, held});
    end
    if (prev_vdd === 1'b1 && vdd_en_n === 1'b0) t_vdd_on = cyc;
    if (prev_vdd === 1'b0 && vdd_en_n === 1'b1) t_vdd_off = cyc;
    if (prev_vbat === 1'b1 && vbat_en_n === 1'b0) t_vbat_on = cyc;
    if (prev_vbat === 1'b0 && vbat_en_n === 1'b1) t_vbat_off = cyc;
    if (prev_valid === 1'b0 && cmd_if.cmd_valid === 1'b1 && t_valid_on < 0) t_valid_on = cyc;
    if (prev_ready === 1'b0 && ready === 1'b1) t_ready_on = cyc;
    if (res_n === 1'b0) res_low_cnt++;
    if (ready === 1'b1) ready_seen = 1'b1;
    prev_vdd = vdd_en_n; prev_vbat = vbat_en_n;
    prev_valid = cmd_if.cmd_valid; prev_ready = ready;
  endtask

  task automatic push_powerup();
    for (int i = 0; i < 12; i++) sb_q.push_back(exp_seq[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 400; i++) begin
      if (ready === 1'b1) break;
      tick();
    end
    chk("ready_reached", {31'd0, ready}, 32'd1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cmd_if.cmd_ready = 1'b1; cmd_if.spi_idle = 1'b1;
    clear_mon();
    repeat (3) tick();
    chk("rst_vdd_en_n", {31'd0, vdd_en_n}, 32'd1);
    chk("rst_vbat_en_n", {31'd0, vbat_en_n}, 32'd1);
    chk("rst_res_n", {31'd0, res_n}, 32'd1);
    chk("rst_dc", {31'd0, cmd_if.dc}, 32'd0);
    chk("rst_cmd_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
    chk("rst_cmd_data", {24'd0, cmd_if.cmd_data}, 32'h00);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Baseline power-up with an always-ready transmitter.
    clear_mon();
    push_powerup();
    pulse_start();
    chk("start_vdd_on", {31'd0, vdd_en_n}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    wait_ready();
    chk("vdd_to_cmd", 32'(t_valid_on - t_vdd_on), T_VDD);
    chk("res_low_cycles", 32'(res_low_cnt), T_RES);
    chk("vdd_to_vbat", 32'(t_vbat_on - t_vdd_on), T_VDD + 2 + 2 * T_RES + 5);
    chk("vdd_to_ready", 32'(t_ready_on - t_vdd_on), T_VDD + 2 + 2 * T_RES + 5 + T_VBAT + 8);
    chk("ready_busy", {31'd0, busy}, 32'd0);
    chk("ready_dc", {31'd0, cmd_if.dc}, 32'd0);
    chk("sb_empty_1", 32'(sb_q.size()), 32'd0);

    // Back-pressure: transmitter ready one cycle in three.
    reset_dut();
    clear_mon();
    rdy_mode = 1;
    push_powerup();
    pulse_start();
    wait_ready();
    chk("sb_empty_2", 32'(sb_q.size()), 32'd0);
    rdy_mode = 0;

    // Transmitter stays busy for 5 cycles after F1; VBAT must slip by exactly that.
    reset_dut();
    clear_mon();
    arm_idle = 1'b1;
    push_powerup();
    pulse_start();
    wait_ready();
    arm_idle = 1'b0;
    chk("vdd_to_vbat_slip", 32'(t_vbat_on - t_vdd_on), T_VDD + 2 + 2 * T_RES + 5 + 5);
    chk("sb_empty_3", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of VBAT_WAIT, then a full replay.
    reset_dut();
    clear_mon();
    push_powerup();
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (vbat_en_n === 1'b0) break;
      tick();
    end
    chk("reach_vbat_wait", {31'd0, vbat_en_n}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_vbat", {31'd0, vbat_en_n}, 32'd1);
    chk("midrst_vdd", {31'd0, vdd_en_n}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_res_n", {31'd0, res_n}, 32'd1);
    chk("midrst_cmd_data", {24'd0, cmd_if.cmd_data}, 32'h00);
    sb_q.delete();
    tick();
    clear_mon();
    push_powerup();
    pulse_start();
    wait_ready();
    chk("replay_vdd_to_vbat", 32'(t_vbat_on - t_vdd_on), T_VDD + 2 + 2 * T_RES + 5);
    chk("sb_empty_4", 32'(sb_q.size()), 32'd0);

`ifdef OLED_SEQ_POWERDOWN_EN
    // Stop from READY: display-off byte, VBAT off, then VDD off T_VBAT later.
    clear_mon();
    sb_q.push_back(8'hAE);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("pd_ready_fall", {31'd0, ready}, 32'd0);
    chk("pd_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 200; i++) begin
      if (vdd_en_n === 1'b1) break;
      tick();
    end
    chk("pd_vdd_off", {31'd0, vdd_en_n}, 32'd1);
    chk("pd_vbat_to_vdd", 32'(t_vdd_off - t_vbat_off), T_VBAT);
    chk("pd_busy_done", {31'd0, busy}, 32'd0);
    chk("sb_empty_pd", 32'(sb_q.size()), 32'd0);

    // Stop during the charge-pump segment: finish power-up, never report ready, power down.
    clear_mon();
    push_powerup();
    sb_q.push_back(8'hAE);
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (cmd_if.cmd_valid === 1'b1 && cmd_if.cmd_data === 8'h8D) break;
      tick();
    end
    chk("reach_pump", {24'd0, cmd_if.cmd_data}, 32'h8D);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (vdd_en_n === 1'b1 && busy === 1'b0) break;
      tick();
    end
    chk("pend_vdd_off", {31'd0, vdd_en_n}, 32'd1);
    chk("pend_ready_never", {31'd0, ready_seen}, 32'd0);
    chk("sb_empty_pend", 32'(sb_q.size()), 32'd0);
`else
    // Without power-down support, stop in READY changes nothing.
    stop = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("stop_ignored", {26'd0, ready, busy, vdd_en_n, vbat_en_n, res_n, cmd_if.cmd_valid},
          32'b100010);
    end
    stop = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/oled_power_sequencer.md
# oled_power_sequencer

Controller that brings the SSD1306 OLED panel from cold to display-on and back, enforcing the datasheet ordering of VDD, RES#, charge-pump setup, VBAT and configuration bytes. It owns a single countdown timer used for every power-rail and reset delay. It feeds command bytes to the SPI byte transmitter over a valid/ready handshake. It sits between top-level control (start/stop) and the SPI/pin layer; higher-level drawing logic waits on `ready`.

## Interface
- `T_VDD`, 100_000: cycles from VDD on to the first command (1 ms at 100 MHz).
- `T_RES`, 100_000: cycles RES# is held low, and again after release.
- `T_VBAT`, 10_000_000: cycles from VBAT on to the configuration bytes, and from VBAT off to VDD off.
- `TW`, 32: timer width; every T_* must be at least 1 and below 2^TW.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: level; begin power-up when in OFF.
- `stop` in 1: level; begin power-down (see Configuration).
- `ready` out 1: panel on and configured.
- `busy` out 1: any state other than OFF and READY.
- `vdd_en_n` out 1: logic supply enable, active-low.
- `vbat_en_n` out 1: panel supply enable, active-low.
- `res_n` out 1: panel reset pin.
- `dc` out 1: data/command select; always 0 (command) from this block.
- `cmd_valid` out 1: `cmd_data` is valid.
- `cmd_data` out 8: command byte.
- `cmd_ready` in 1: transmitter accepts a byte when valid & ready.
- `spi_idle` in 1: transmitter has finished shifting all accepted bytes.

## Operation
- Reset values: `vdd_en_n`=1, `vbat_en_n`=1, `res_n`=1, `dc`=0, `cmd_valid`=0, `cmd_data`=0x00, `ready`=0, `busy`=0. The FSM goes to OFF and the timer clears.
- Command ROM, 13 bytes, indexed 0..12: AE, 8D, 14, D9, F1, 81, 0F, A1, C8, DA, 20, AF, AE.
- Power-up states, in order:
  - OFF: waits for `start`.
  - VDD_WAIT: `vdd_en_n`=0; wait T_VDD.
  - SEND0: byte 0.
  - RES_LOW: `res_n`=0; wait T_RES.
  - RES_HIGH: `res_n`=1; wait T_RES.
  - SEND_PUMP: bytes 1–4.
  - VBAT_WAIT: `vbat_en_n`=0; wait T_VBAT.
  - SEND_CFG: bytes 5–11.
  - READY.
- Power-down states (macro only):
  - PD_SEND: byte 12.
  - PD_VBAT: `vbat_en_n`=1; wait T_VBAT.
  - Then OFF with `vdd_en_n`=1.
- Send states: present ROM[idx] with `cmd_valid`=1. Advance idx on each valid & ready. After the last byte, drop `cmd_valid`, then hold until `spi_idle`=1 before leaving the state.
- While `cmd_ready`=0, `cmd_valid` and `cmd_data` hold stable.
- `start` is ignored outside OFF. `start` and `stop` asserted together in OFF: start wins. Together in READY: stop wins.
- Rail enables and `res_n` are registered outputs and never glitch.

## Timing
- `start` sampled high in OFF at edge k: `vdd_en_n`=0 and `busy`=1 from edge k+1.
- Wait state entered at edge e: the timer loads T−1. The state exits at edge e+T, so the entry condition holds exactly T cycles.
- A byte is accepted on every cycle with valid & ready; there are no bubbles between bytes of a segment.
- With `cmd_ready` and `spi_idle` tied high, each send segment of n bytes occupies n+1 cycles (n bytes plus the idle-check cycle).
- `ready` rises on the edge after the SEND_CFG idle check passes, and falls on the edge that leaves READY.
- Reset asserted mid-sequence: on the next edge, all outputs go to their reset values, even though this drops the rails abruptly.

## Configuration
- `OLED_SEQ_POWERDOWN_EN` defined:
  - `stop` in READY enters PD_SEND.
  - `stop` during power-up is latched as pending and acted on at READY entry; `ready` then stays 0.
- `OLED_SEQ_POWERDOWN_EN` undefined:
  - `stop` is ignored and PD states and ROM byte 12 are absent.
  - Only `rst` returns the block to OFF.

## Structure
- Package `oled_seq_pkg`: state enum, command ROM as a localparam array, and segment start/end index constants.
- Sub-module `oled_seq_timer`: inputs `load` and `n`, output `done`; loadable down-counter of width TW.

## Test plan
- Params T_VDD=10, T_RES=3, T_VBAT=20, `cmd_ready`=`spi_idle`=1; pulse `start` → bytes AE,8D,14,D9,F1,81,0F,A1,C8,DA,20,AF in order, `ready`=1; VDD on exactly 10 cycles before the first `cmd_valid`; `res_n` low exactly 3 cycles.
- `cmd_ready` toggled 1-of-3 cycles → same byte order; `cmd_data` stable while valid & !ready.
- `spi_idle` held 0 for 5 cycles after byte F1 → `vbat_en_n` falls exactly 5 cycles later than the baseline run.
- `rst` pulsed during VBAT_WAIT → next edge: `vbat_en_n`=`vdd_en_n`=1, `busy`=0; a new `start` replays the full sequence.
- With macro: `stop` in READY → byte AE, `vbat_en_n`=1, 20 cycles later `vdd_en_n`=1. `stop` during SEND_PUMP → completes to READY entry, then powers down.
- Without macro: `stop` in READY → no change for 100 cycles.
